alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single ALU datapath between two requesters: port 0 is the execute stage, port 1 is the branch/address unit.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Round-robin grant; exactly one operation in flight.
- Drives the ALU inputs read_data1, read_data2 and control_signal, then captures result and zero_bit after a fixed latency.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CTRL_WIDTH, 4, ALU control_signal width.
- ALU_LATENCY, 1, cycles from operand drive to valid ALU result. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- req_valid_0 / req_valid_1  in  1  request pending on port 0 / 1.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_operand_a_0 / req_operand_a_1  in  DATA_WIDTH  first operand.
- req_operand_b_0 / req_operand_b_1  in  DATA_WIDTH  second operand.
- req_control_0 / req_control_1  in  CTRL_WIDTH  ALU operation code.
- resp_valid_0 / resp_valid_1  out  1  response available.
- resp_ready_0 / resp_ready_1  in  1  requester consumes response.
- resp_result  out  DATA_WIDTH  captured ALU result, shared by both ports.
- resp_zero  out  1  captured ALU zero_bit.
- alu_read_data1  out  DATA_WIDTH  to ALU read_data1.
- alu_read_data2  out  DATA_WIDTH  to ALU read_data2.
- alu_control_signal  out  CTRL_WIDTH  to ALU control_signal.
- alu_result  in  DATA_WIDTH  from ALU result.
- alu_zero_bit  in  1  from ALU zero_bit.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE, rr_pointer = 0.
  - All ready/valid outputs 0; resp_result = 0; resp_zero = 0.
  - alu_* outputs = 0; control 0000 is AND, so 0 & 0 is harmless.
- State IDLE:
  - Grant selection is combinational: if only one req_valid is high, grant it. If both are high, grant the port equal to rr_pointer.
  - req_ready of the granted port is high in the same cycle. That cycle is the handshake.
  - On handshake: latch operands, control code and granted id into holding registers; rr_pointer <= ~granted id; go to EXEC with wait counter = ALU_LATENCY-1.
- State EXEC:
  - alu_* outputs driven from the holding registers, stable for the whole state.
  - Counter decrements each cycle. When the counter is 0, capture alu_result into resp_result and alu_zero_bit into resp_zero, then go to RESP.
  - Total: result is captured ALU_LATENCY cycles after the first EXEC cycle. Request handshake to resp_valid is ALU_LATENCY+1 cycles.
- State RESP:
  - resp_valid of the latched id is high; the other port's resp_valid stays low.
  - resp_result and resp_zero are held stable until the handshake.
  - On resp_valid && resp_ready: go to IDLE. A new grant is possible in the next cycle, never the same cycle.
- req_ready is low in EXEC and RESP.
- Control codes are passed through unmodified. Undefined codes are not checked; whatever the ALU returns is forwarded.
- A requester dropping req_valid before its handshake is legal and causes no grant.
- Reset asserted mid-EXEC or mid-RESP: the operation is discarded, no response is ever issued, and rr_pointer returns to 0.
- Arithmetic: no width changes; all buses are DATA_WIDTH pass-through.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs stat_grants_0 and stat_grants_1 (32-bit each) counting request handshakes per port, and stat_conflicts (32-bit) counting IDLE cycles with both req_valid high.
  - Counters wrap modulo 2^32.
  - Cleared by reset only.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - ALU control code constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, and codes 0100 and 0101.
  - The FSM state encoding: IDLE, EXEC, RESP.
  - DATA_WIDTH and CTRL_WIDTH defaults.
- One sub-module rr_arbiter_2:
  - Inputs: two requests, rr_pointer and an enable.
  - Outputs: a one-hot grant.
  - Purely combinational. The pointer register lives in alu_arbiter.

Test Plan:
- Port 0 only, a=12, b=12, control=0010 -> resp_valid_0 after ALU_LATENCY+1 cycles, resp_result=24, resp_zero=0; resp_valid_1 never rises.
- Port 1 only, a=12, b=12, control=0110 -> resp_result=0, resp_zero=1 on port 1.
- Both ports valid from reset, port 0 AND 12,12 and port 1 OR 5,10 -> port 0 granted first (result 12), then port 1 (result 15). A repeat of the simultaneous pair grants port 1 first.
- resp_ready_0 held low for 5 cycles -> resp_valid_0, resp_result and resp_zero are stable throughout; req_ready_1 stays low until the cycle after the response handshake.
- reset_n pulsed low during EXEC -> all outputs 0 immediately (asynchronous); no response appears after release; the next simultaneous request grants port 0.
- With ALU_ARB_STATS_EN and 3 simultaneous-request rounds -> stat_grants_0=3, stat_grants_1=3, stat_conflicts at least 3.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice (package alu_pkg).
// ALU control codes, FSM state encoding and default bus widths.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_CTRL_WIDTH = 4;

    // ALU control codes; the arbiter forwards them untouched
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_OP_0100 = 4'b0100;
    localparam logic [3:0] ALU_OP_0101 = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two request and two response
// valid/ready channels plus the shared response payload.
//   master : requester view (drives requests, consumes responses)
//   slave  : arbiter view
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = DEFAULT_CTRL_WIDTH
);
    logic                  req_valid_0;
    logic                  req_valid_1;
    logic                  req_ready_0;
    logic                  req_ready_1;
    logic [DATA_WIDTH-1:0] req_operand_a_0;
    logic [DATA_WIDTH-1:0] req_operand_a_1;
    logic [DATA_WIDTH-1:0] req_operand_b_0;
    logic [DATA_WIDTH-1:0] req_operand_b_1;
    logic [CTRL_WIDTH-1:0] req_control_0;
    logic [CTRL_WIDTH-1:0] req_control_1;
    logic                  resp_valid_0;
    logic                  resp_valid_1;
    logic                  resp_ready_0;
    logic                  resp_ready_1;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;

    modport master (
        output req_valid_0, req_valid_1,
        output req_operand_a_0, req_operand_a_1,
        output req_operand_b_0, req_operand_b_1,
        output req_control_0, req_control_1,
        output resp_ready_0, resp_ready_1,
        input  req_ready_0, req_ready_1,
        input  resp_valid_0, resp_valid_1,
        input  resp_result, resp_zero
    );

    modport slave (
        input  req_valid_0, req_valid_1,
        input  req_operand_a_0, req_operand_a_1,
        input  req_operand_b_0, req_operand_b_1,
        input  req_control_0, req_control_1,
        input  resp_ready_0, resp_ready_1,
        output req_ready_0, req_ready_1,
        output resp_valid_0, resp_valid_1,
        output resp_result, resp_zero
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant, purely combinational.
//   req     : request vector (bit n = port n)
//   pointer : preferred port when both request
//   enable  : gates all grants
//   grant   : one-hot grant
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       pointer,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || !pointer)) begin
                grant[0] = 1'b1;
            end else if (req[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the branch/address
// unit (port 1). Round-robin grant, one operation in flight, result captured
// ALU_LATENCY cycles after the operands are driven.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   bus (slave)          : request/response handshakes and shared response
//   alu_read_data1/2     : operands to the ALU
//   alu_control_signal   : operation code to the ALU
//   alu_result/zero_bit  : ALU outputs
//   stat_*               : handshake/conflict counters (only with ALU_ARB_STATS_EN)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH  = DEFAULT_CTRL_WIDTH,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_arbiter_if.slave          bus,
    output logic [DATA_WIDTH-1:0] alu_read_data1,
    output logic [DATA_WIDTH-1:0] alu_read_data2,
    output logic [CTRL_WIDTH-1:0] alu_control_signal,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero_bit
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grants_0,
    output logic [31:0]           stat_grants_1,
    output logic [31:0]           stat_conflicts
`endif
);

    localparam int unsigned CNT_W = 3;

    arb_state_t            state;
    logic                  rr_pointer;
    logic                  resp_id;
    logic [CNT_W-1:0]      wait_cnt;
    logic [1:0]            grant;
    logic                  resp_valid_0;
    logic                  resp_valid_1;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;

    // reset_n in the enable keeps req_ready low while reset is asserted
    rr_arbiter_2 u_rr (
        .req     ({bus.req_valid_1, bus.req_valid_0}),
        .pointer (rr_pointer),
        .enable  ((state == IDLE) && reset_n),
        .grant   (grant)
    );

    assign bus.req_ready_0  = grant[0];
    assign bus.req_ready_1  = grant[1];
    assign bus.resp_valid_0 = resp_valid_0;
    assign bus.resp_valid_1 = resp_valid_1;
    assign bus.resp_result  = resp_result;
    assign bus.resp_zero    = resp_zero;

    // Arbitration FSM; the holding registers drive the ALU directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            rr_pointer         <= 1'b0;
            resp_id            <= 1'b0;
            wait_cnt           <= '0;
            resp_valid_0       <= 1'b0;
            resp_valid_1       <= 1'b0;
            resp_result        <= '0;
            resp_zero          <= 1'b0;
            alu_read_data1     <= '0;
            alu_read_data2     <= '0;
            alu_control_signal <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_read_data1     <= grant[1] ? bus.req_operand_a_1 : bus.req_operand_a_0;
                        alu_read_data2     <= grant[1] ? bus.req_operand_b_1 : bus.req_operand_b_0;
                        alu_control_signal <= grant[1] ? bus.req_control_1   : bus.req_control_0;
                        resp_id            <= grant[1];
                        rr_pointer         <= ~grant[1];
                        wait_cnt           <= CNT_W'(ALU_LATENCY - 1);
                        state              <= EXEC;
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        resp_result  <= alu_result;
                        resp_zero    <= alu_zero_bit;
                        resp_valid_0 <= ~resp_id;
                        resp_valid_1 <= resp_id;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if ((resp_valid_0 && bus.resp_ready_0) || (resp_valid_1 && bus.resp_ready_1)) begin
                        resp_valid_0 <= 1'b0;
                        resp_valid_1 <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Free-running wrap-around counters, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants_0  <= '0;
            stat_grants_1  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant[0]) begin
                stat_grants_0 <= stat_grants_0 + 32'd1;
            end
            if (grant[1]) begin
                stat_grants_1 <= stat_grants_1 + 32'd1;
            end
            if ((state == IDLE) && bus.req_valid_0 && bus.req_valid_1) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
// Build with ALU_ARB_STATS_EN defined to also check the statistics counters.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] alu_read_data1;
    logic [DW-1:0] alu_read_data2;
    logic [CW-1:0] alu_control_signal;
    logic [DW-1:0] alu_result;
    logic          alu_zero_bit;
    logic          alu_force;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   stat_grants_0;
    logic [31:0]   stat_grants_1;
    logic [31:0]   stat_conflicts;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ALU_LATENCY(1)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus                (bus),
        .alu_read_data1     (alu_read_data1),
        .alu_read_data2     (alu_read_data2),
        .alu_control_signal (alu_control_signal),
        .alu_result         (alu_result),
        .alu_zero_bit       (alu_zero_bit)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grants_0      (stat_grants_0),
        .stat_grants_1      (stat_grants_1),
        .stat_conflicts     (stat_conflicts)
`endif
    );

    // Behavioural ALU; alu_force corrupts its outputs to prove the capture is held
    always_comb begin
        alu_result = '0;
        case (alu_control_signal)
            ALU_AND: alu_result = alu_read_data1 & alu_read_data2;
            ALU_OR:  alu_result = alu_read_data1 | alu_read_data2;
            ALU_ADD: alu_result = alu_read_data1 + alu_read_data2;
            ALU_SUB: alu_result = alu_read_data1 - alu_read_data2;
            default: alu_result = alu_read_data1 ^ alu_read_data2;
        endcase
        alu_zero_bit = (alu_result == '0);
        if (alu_force) begin
            alu_result   = 32'hDEAD_BEEF;
            alu_zero_bit = 1'b1;
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0b required %0b", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        if (p == 0) begin
            bus.req_valid_0 = 1'b1; bus.req_operand_a_0 = a; bus.req_operand_b_0 = b; bus.req_control_0 = c;
        end else begin
            bus.req_valid_1 = 1'b1; bus.req_operand_a_1 = a; bus.req_operand_b_1 = b; bus.req_control_1 = c;
        end
    endtask

    // Single uncontended transaction, checked cycle by cycle
    task automatic single(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] exp_r, input logic exp_z);
        set_req(p, a, b, c);
        #1;
        chk1({tag, "_ready"}, (p == 0) ? bus.req_ready_0 : bus.req_ready_1, 1'b1);
        chk1({tag, "_ready_other"}, (p == 0) ? bus.req_ready_1 : bus.req_ready_0, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        chk1({tag, "_exec_no_valid"}, bus.resp_valid_0 | bus.resp_valid_1, 1'b0);
        chk32({tag, "_alu_a"}, alu_read_data1, a);
        chk32({tag, "_alu_ctrl"}, 32'(alu_control_signal), 32'(c));
        tick();
        chk1({tag, "_resp_valid"}, (p == 0) ? bus.resp_valid_0 : bus.resp_valid_1, 1'b1);
        chk1({tag, "_resp_valid_other"}, (p == 0) ? bus.resp_valid_1 : bus.resp_valid_0, 1'b0);
        chk32({tag, "_result"}, bus.resp_result, exp_r);
        chk1({tag, "_zero"}, bus.resp_zero, exp_z);
        if (p == 0) bus.resp_ready_0 = 1'b1; else bus.resp_ready_1 = 1'b1;
        tick();
        bus.resp_ready_0 = 1'b0;
        bus.resp_ready_1 = 1'b0;
        chk1({tag, "_resp_done"}, bus.resp_valid_0 | bus.resp_valid_1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_force = 1'b0;
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        bus.req_operand_a_0 = '0; bus.req_operand_b_0 = '0; bus.req_control_0 = '0;
        bus.req_operand_a_1 = '0; bus.req_operand_b_1 = '0; bus.req_control_1 = '0;
        bus.resp_ready_0 = 1'b0; bus.resp_ready_1 = 1'b0;

        // Reset state, with a request pending that must not be accepted
        reset_n = 1'b0;
        set_req(0, 32'd1, 32'd1, ALU_ADD);
        #2;
        chk1("rst_req_ready_0", bus.req_ready_0, 1'b0);
        chk1("rst_req_ready_1", bus.req_ready_1, 1'b0);
        chk1("rst_resp_valid_0", bus.resp_valid_0, 1'b0);
        chk1("rst_resp_valid_1", bus.resp_valid_1, 1'b0);
        chk32("rst_resp_result", bus.resp_result, 32'd0);
        chk1("rst_resp_zero", bus.resp_zero, 1'b0);
        chk32("rst_alu_a", alu_read_data1, 32'd0);
        chk32("rst_alu_b", alu_read_data2, 32'd0);
        chk32("rst_alu_ctrl", 32'(alu_control_signal), 32'd0);
        bus.req_valid_0 = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Uncontended port 0 add and port 1 subtract
        single("p0_add", 0, 32'd12, 32'd12, ALU_ADD, 32'd24, 1'b0);
        single("p1_sub", 1, 32'd12, 32'd12, ALU_SUB, 32'd0, 1'b1);

        // Simultaneous requests after reset: port 0 first, then port 1 wins the repeat
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_req(0, 32'd12, 32'd12, ALU_AND);
        set_req(1, 32'd5, 32'd10, ALU_OR);
        #1;
        chk1("rr1_ready_0", bus.req_ready_0, 1'b1);
        chk1("rr1_ready_1", bus.req_ready_1, 1'b0);
        tick();
        chk1("rr1_exec_ready_1", bus.req_ready_1, 1'b0);
        tick();
        chk1("rr1_resp_valid_0", bus.resp_valid_0, 1'b1);
        chk32("rr1_result", bus.resp_result, 32'd12);
        chk1("rr1_resp_ready_1", bus.req_ready_1, 1'b0);
        bus.resp_ready_0 = 1'b1;
        tick();
        bus.resp_ready_0 = 1'b0;
        chk1("rr2_ready_1", bus.req_ready_1, 1'b1);
        chk1("rr2_ready_0", bus.req_ready_0, 1'b0);
        tick();
        bus.req_valid_1 = 1'b0;
        tick();
        chk1("rr2_resp_valid_1", bus.resp_valid_1, 1'b1);
        chk1("rr2_resp_valid_0", bus.resp_valid_0, 1'b0);
        chk32("rr2_result", bus.resp_result, 32'd15);
        chk1("rr2_zero", bus.resp_zero, 1'b0);
        bus.resp_ready_1 = 1'b1;
        tick();
        bus.resp_ready_1 = 1'b0;
        chk1("rr3_ready_0", bus.req_ready_0, 1'b1);
        tick();
        bus.req_valid_0 = 1'b0;
        tick();
        chk32("rr3_result", bus.resp_result, 32'd12);
        bus.resp_ready_0 = 1'b1;
        tick();
        bus.resp_ready_0 = 1'b0;

        // Back-pressured response held for five cycles while port 1 waits
        set_req(0, 32'd7, 32'd9, ALU_ADD);
        #1;
        chk1("bp_ready_0", bus.req_ready_0, 1'b1);
        tick();
        bus.req_valid_0 = 1'b0;
        set_req(1, 32'd1, 32'd1, ALU_ADD);
        chk1("bp_exec_ready_1", bus.req_ready_1, 1'b0);
        tick();
        alu_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_hold_valid_0", bus.resp_valid_0, 1'b1);
            chk32("bp_hold_result", bus.resp_result, 32'd16);
            chk1("bp_hold_zero", bus.resp_zero, 1'b0);
            chk1("bp_hold_ready_1", bus.req_ready_1, 1'b0);
            tick();
        end
        alu_force = 1'b0;
        bus.resp_ready_0 = 1'b1;
        #1;
        chk1("bp_hs_ready_1", bus.req_ready_1, 1'b0);
        tick();
        bus.resp_ready_0 = 1'b0;
        chk1("bp_after_valid_0", bus.resp_valid_0, 1'b0);
        chk1("bp_after_ready_1", bus.req_ready_1, 1'b1);
        tick();
        bus.req_valid_1 = 1'b0;
        tick();
        chk1("bp_p1_valid", bus.resp_valid_1, 1'b1);
        chk32("bp_p1_result", bus.resp_result, 32'd2);
        bus.resp_ready_1 = 1'b1;
        tick();
        bus.resp_ready_1 = 1'b0;

        // Reset in EXEC discards the operation and returns the pointer to port 0
        set_req(0, 32'd3, 32'd4, ALU_ADD);
        tick();
        bus.req_valid_0 = 1'b0;
        chk32("mid_alu_a", alu_read_data1, 32'd3);
        reset_n = 1'b0;
        #1;
        chk32("mid_rst_alu_a", alu_read_data1, 32'd0);
        chk32("mid_rst_alu_ctrl", 32'(alu_control_signal), 32'd0);
        chk1("mid_rst_valid_0", bus.resp_valid_0, 1'b0);
        chk32("mid_rst_result", bus.resp_result, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("mid_no_resp", bus.resp_valid_0 | bus.resp_valid_1, 1'b0);
        end
        set_req(0, 32'd3, 32'd4, ALU_ADD);
        set_req(1, 32'd8, 32'd8, ALU_ADD);
        #1;
        chk1("mid_next_ready_0", bus.req_ready_0, 1'b1);
        chk1("mid_next_ready_1", bus.req_ready_1, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        tick();
        chk32("mid_next_result", bus.resp_result, 32'd7);
        bus.resp_ready_0 = 1'b1;
        tick();
        bus.resp_ready_0 = 1'b0;

`ifdef ALU_ARB_STATS_EN
        // Three contended rounds: grants alternate between ports
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 32'd2, 32'd2, ALU_ADD);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) begin
                bus.req_valid_0 = 1'b0;
                bus.req_valid_1 = 1'b0;
            end
            tick();
            bus.resp_ready_0 = 1'b1;
            bus.resp_ready_1 = 1'b1;
            tick();
            bus.resp_ready_0 = 1'b0;
            bus.resp_ready_1 = 1'b0;
        end
        chk32("stat_grants_0", stat_grants_0, 32'd3);
        chk32("stat_grants_1", stat_grants_1, 32'd3);
        chk1("stat_conflicts_ge3", stat_conflicts >= 32'd3, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
